// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Resolves data-memory wait (full freeze) > load-use (front-end stall +
// ID_EX bubble) > taken branch (IF_ID flush). Outputs are combinational
// from registered state and current inputs.
// Optional: define HAZARD_PERF_CNT_EN to add stall_cnt_o / flush_cnt_o.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ID_EX_MemRead_i,
  input  logic [4:0] ID_EX_Rt_i,
  input  logic [4:0] IF_ID_Rs_i,
  input  logic [4:0] IF_ID_Rt_i,
  input  logic       branch_taken_i,
  input  logic       mem_req_i,
  input  logic       mem_ready_i,
  output logic       PC_write_o,
  output logic       IF_ID_write_o,
  output logic       IF_ID_flush_o,
  output logic       ID_EX_write_o,
  output logic       ID_EX_bubble_o,
  output logic       EX_MEM_write_o,
  output logic       MEM_WB_bubble_o,
  output logic       mem_err_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic               mem_err, mem_err_nxt;
  // Set for the one cycle after a timeout: the abandoned access is treated
  // as complete even though mem_req_i may still be high.
  logic               dropped, dropped_nxt;
  logic               freeze;
  logic               loaduse;

  assign freeze = !dropped &&
                  (((state == RUN) && mem_req_i && !mem_ready_i) ||
                   ((state == MEM_WAIT) && !mem_ready_i));

  assign loaduse = ID_EX_MemRead_i && (ID_EX_Rt_i != 5'd0) &&
                   ((ID_EX_Rt_i == IF_ID_Rs_i) || (ID_EX_Rt_i == IF_ID_Rt_i));

  // State register: FSM state, wait counter, sticky error, drop marker.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err_nxt;
      dropped  <= dropped_nxt;
    end
  end

  // Next-state and pipeline control outputs, priority freeze > loaduse > flush.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = mem_err;
    dropped_nxt  = 1'b0;

    unique case (state)
      RUN: begin
        if (!dropped && mem_req_i && !mem_ready_i) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready_i) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
          mem_err_nxt  = 1'b1;
          dropped_nxt  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = RUN;
    endcase

    PC_write_o      = 1'b1;
    IF_ID_write_o   = 1'b1;
    IF_ID_flush_o   = 1'b0;
    ID_EX_write_o   = 1'b1;
    ID_EX_bubble_o  = 1'b0;
    EX_MEM_write_o  = 1'b1;
    MEM_WB_bubble_o = 1'b0;
    mem_err_o       = mem_err && !rst_i;

    if (rst_i) begin
      PC_write_o      = 1'b0;
      IF_ID_write_o   = 1'b0;
      IF_ID_flush_o   = 1'b1;
      ID_EX_write_o   = 1'b0;
      ID_EX_bubble_o  = 1'b1;
      EX_MEM_write_o  = 1'b0;
      MEM_WB_bubble_o = 1'b1;
    end else if (freeze) begin
      PC_write_o      = 1'b0;
      IF_ID_write_o   = 1'b0;
      ID_EX_write_o   = 1'b0;
      EX_MEM_write_o  = 1'b0;
      MEM_WB_bubble_o = 1'b1;
    end else if (loaduse) begin
      PC_write_o      = 1'b0;
      IF_ID_write_o   = 1'b0;
      ID_EX_bubble_o  = 1'b1;
    end else if (branch_taken_i) begin
      IF_ID_flush_o   = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters: stall cycles and IF_ID flush cycles, wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (freeze || loaduse) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (IF_ID_flush_o)     flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl (TIMEOUT=4): directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO = 4;

  // Output vector order: PC, IF_ID_w, IF_ID_flush, ID_EX_w, ID_EX_bub,
  // EX_MEM_w, MEM_WB_bub, mem_err
  localparam logic [7:0] V_RST   = 8'b0010_1010;
  localparam logic [7:0] V_IDLE  = 8'b1101_0100;
  localparam logic [7:0] V_LU    = 8'b0001_1100;
  localparam logic [7:0] V_FLUSH = 8'b1111_0100;
  localparam logic [7:0] V_FRZ   = 8'b0000_0010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       memread = 1'b0;
  logic [4:0] ex_rt = '0, id_rs = '0, id_rt = '0;
  logic       br = 1'b0, req = 1'b0, rdy = 1'b0;
  logic       pc_w, ifid_w, ifid_fl, idex_w, idex_bub, exmem_w, memwb_bub, err;
  logic [7:0] outs;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .ID_EX_MemRead_i(memread), .ID_EX_Rt_i(ex_rt),
    .IF_ID_Rs_i(id_rs), .IF_ID_Rt_i(id_rt),
    .branch_taken_i(br), .mem_req_i(req), .mem_ready_i(rdy),
    .PC_write_o(pc_w), .IF_ID_write_o(ifid_w), .IF_ID_flush_o(ifid_fl),
    .ID_EX_write_o(idex_w), .ID_EX_bubble_o(idex_bub),
    .EX_MEM_write_o(exmem_w), .MEM_WB_bubble_o(memwb_bub), .mem_err_o(err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
  );

  assign outs = {pc_w, ifid_w, ifid_fl, idex_w, idex_bub, exmem_w, memwb_bub, err};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: an access is outstanding until ready arrives or it has
  // been frozen for TO+1 cycles; the cycle after an abort ignores mem_req.
  bit pending = 0;
  int frozen  = 0;
  bit aborted = 0;
  bit m_err   = 0;
  int m_stall = 0;
  int m_flush = 0;

  initial begin
    @(posedge clk);
    forever begin
      bit fz, lu, fl;
      logic [7:0] exp;
      @(negedge clk);
      fz = !rst && !rdy && (pending || (req && !aborted));
      lu = !rst && memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
      fl = !rst && !fz && !lu && br;
      if (rst)     exp = V_RST;
      else if (fz) exp = V_FRZ;
      else if (lu) exp = V_LU;
      else if (fl) exp = V_FLUSH;
      else         exp = V_IDLE;
      if (!rst) exp[0] = m_err;
      check("model_outs", {24'd0, outs}, {24'd0, exp});
`ifdef HAZARD_PERF_CNT_EN
      check("model_stall_cnt", stall_cnt, m_stall);
      check("model_flush_cnt", flush_cnt, m_flush);
`endif
      if (rst) begin
        pending = 0; frozen = 0; aborted = 0; m_err = 0; m_stall = 0; m_flush = 0;
      end else begin
        aborted = 0;
        if (fz) begin
          frozen++;
          if (frozen == TO + 1) begin
            pending = 0; frozen = 0; m_err = 1; aborted = 1;
          end else begin
            pending = 1;
          end
        end else begin
          pending = 0; frozen = 0;
        end
        if (fz || lu) m_stall++;
        if (fl)       m_flush++;
      end
    end
  end

  task automatic apply(input logic r, input logic m, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic b, input logic q, input logic y);
    @(posedge clk);
    #1;
    rst = r; memread = m; ex_rt = ert; id_rs = rs; id_rt = rt;
    br = b; req = q; rdy = y;
  endtask

  task automatic peek(input string name, input logic [7:0] exp);
    @(negedge clk);
    #1;
    check(name, {24'd0, outs}, {24'd0, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      apply(1, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
      peek("reset", V_RST);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0);   peek("idle_after_reset", V_IDLE);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_reset", stall_cnt, 0);
`endif
    // Load-use
    apply(0, 1, 5, 5, 3, 0, 0, 0);   peek("loaduse_rs", V_LU);
    apply(0, 1, 0, 0, 0, 0, 0, 0);   peek("loaduse_r0", V_IDLE);
    apply(0, 1, 9, 4, 2, 0, 0, 0);   peek("load_no_match", V_IDLE);
    // Branch vs load-use
    apply(0, 0, 0, 0, 0, 1, 0, 0);   peek("branch_flush", V_FLUSH);
    apply(0, 1, 7, 1, 7, 1, 0, 0);   peek("loaduse_over_branch", V_LU);
    // Memory wait of 3 cycles with hazards present
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 7, 7, 7, 1, 1, 0); peek("mem_wait_freeze", V_FRZ);
    end
    apply(0, 0, 0, 0, 0, 1, 1, 1);   peek("mem_ready_advance", V_FLUSH);
    apply(0, 0, 0, 0, 0, 0, 0, 0);   peek("after_wait_run", V_IDLE);
    apply(0, 0, 0, 0, 0, 0, 1, 1);   peek("req_ready_same_cycle", V_IDLE);
    // Timeout
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 0, 0, 0, 0, 1, 0); peek("timeout_freeze", V_FRZ);
    end
    apply(0, 0, 0, 0, 0, 0, 1, 0);   peek("timeout_drop", V_IDLE | 8'h01);
    apply(0, 0, 0, 0, 0, 0, 0, 0);   peek("err_sticky", V_IDLE | 8'h01);
    apply(0, 1, 3, 3, 0, 0, 0, 0);   peek("loaduse_with_err", V_LU | 8'h01);
    apply(1, 0, 0, 0, 0, 0, 0, 0);   peek("reset_clears_err", V_RST);
    apply(0, 0, 0, 0, 0, 0, 0, 0);   peek("err_cleared", V_IDLE);
    // Reset in the middle of a wait
    apply(0, 0, 0, 0, 0, 0, 1, 0);   peek("wait_then_reset_a", V_FRZ);
    apply(0, 0, 0, 0, 0, 0, 1, 0);   peek("wait_then_reset_b", V_FRZ);
    apply(1, 0, 0, 0, 0, 0, 1, 0);   peek("reset_mid_wait", V_RST);
    apply(0, 0, 0, 0, 0, 0, 0, 0);   peek("run_after_reset", V_IDLE);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_after_reset", stall_cnt, 0);
`endif
    // Mixed vectors checked by the model only; small register set to hit matches
    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 49) == 0), 1'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
